paddle_array: RTL and testbench
===============================

# paddle_array

Multi-channel paddle input controller: debounces one up/down button pair per player and votes each pair's input over a fixed sampling window. At each window close it emits a signed per-player position change. It generalises the single-paddle block to `NUM_PADDLES` channels, a configurable majority threshold and an optional hold-to-accelerate speed ramp. It sits between the board push-buttons and the game-state/paddle-position logic.

## Interface
- `NUM_PADDLES`, 2: number of independent paddle channels.
- `WINDOW_CLOCKS`, 250000: sampling window length in clocks; must be ≥2.
- `DEBOUNCE_WIDTH_IN_CLOCKS`, 50000: stable-input width required by each debounce stage.
- `VOTE_THRESHOLD`, `WINDOW_CLOCKS`: required magnitude of the window delta sum. Elaboration assertion: `WINDOW_CLOCKS/2 < VOTE_THRESHOLD ≤ WINDOW_CLOCKS`.
- `MAX_SPEED`, 4: maximum step magnitude per window; must be ≥1.
- `ACCEL_WINDOWS`, 8: number of consecutive same-direction windows per speed increment.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `button_up`  in  `NUM_PADDLES`  raw up buttons, bit i = paddle i.
- `button_down`  in  `NUM_PADDLES`  raw down buttons.
- `position_change`  out  `NUM_PADDLES` × `SPEED_W`  signed step per paddle. `SPEED_W = $clog2(MAX_SPEED+1)+1`.
- `change_valid`  out  1  one-cycle strobe marking a fresh `position_change` set.

## Operation
- Per channel, the debounced delta is `up − down`: +1, 0 or −1. Both buttons pressed gives 0.
- A shared window counter runs 0…`WINDOW_CLOCKS−1`, then wraps. Windows are fixed-phase from reset release.
- Each channel has a signed accumulator of width `$clog2(WINDOW_CLOCKS+1)+1`. It adds the delta every cycle.
- Close cycle is counter == `WINDOW_CLOCKS−1`. The vote uses the sum including that cycle's delta:
  - sum ≥ `VOTE_THRESHOLD`: direction UP.
  - sum ≤ −`VOTE_THRESHOLD`: direction DOWN.
  - otherwise: NONE.
- Also in the close cycle, the accumulator restarts. Next window's first sample is the following cycle.
- Output sign is screen-Y: UP → negative, DOWN → positive, NONE → 0. Output magnitude = channel speed.
- Speed per channel is 1 when the feature is off, or as described under Configuration.
- All channels are evaluated in the same close cycle. They never interact.

## Timing
- Reset values:
  - `position_change` all 0.
  - `change_valid` 0.
  - window counter 0.
  - accumulators 0.
  - debounce stages clear (debounced 0).
  - speed 1; run count 0.
- Reset asserted mid-window discards the partial window. The first close occurs `WINDOW_CLOCKS` cycles after the first non-reset cycle.
- Outputs are registered. `position_change` and `change_valid` update on the clock edge ending the close cycle, so latency is 1 cycle after close.
- `change_valid` is high for exactly one cycle per window. `position_change` holds until the next update.
- Input-to-vote latency adds the debounce delay, `DEBOUNCE_WIDTH_IN_CLOCKS` plus a 2-flop synchroniser per button.
- Accumulator never overflows: |sum| ≤ `WINDOW_CLOCKS`.

## Configuration
- `PADDLE_ACCEL_EN` defined:
  - Each channel keeps a run counter and a speed register, 1…`MAX_SPEED`.
  - A window with the same non-NONE direction as the previous window increments the run counter. When the run counter reaches `ACCEL_WINDOWS`, it clears and speed increments, saturating at `MAX_SPEED`.
  - A NONE window or a reversal resets speed to 1 and the run counter to 0. A reversal window outputs ±1 in the new direction.
  - The output uses the speed after the update.
- Macro undefined:
  - No run or speed registers. Magnitude is always 1.
  - `SPEED_W` and port widths are unchanged.

## Structure
- Package `paddle_pkg` holds:
  - the `paddle_dir_t` enum: NONE, UP, DOWN.
  - the width helper functions for `SPEED_W` and accumulator width.
  - the `dir_to_step` function: direction × speed → signed step.
- Sub-module `paddle_channel` holds, per channel:
  - two debounce stages
  - the accumulator
  - the vote
  - the speed logic
- Top `paddle_array` holds the shared window counter and the close strobe. It instantiates `paddle_channel` via a generate loop and registers the outputs.

## Test plan
Bench parameters: `WINDOW_CLOCKS`=16, `DEBOUNCE`=4, `VOTE_THRESHOLD`=12, `MAX_SPEED`=3, `ACCEL_WINDOWS`=2.
1. Reset release, no buttons → outputs 0; first `change_valid` exactly 16 cycles after release, then every 16, with `position_change`={0,0}.
2. Paddle 0 up debounced high for a full window, paddle 1 idle → {−1, 0}; swap to paddle 1 down → {0, +1}.
3. Paddle 0 up high for exactly 11 debounced cycles of a window → 0; 12 cycles → −1.
4. Both buttons of paddle 0 held full window → 0; bounce shorter than 4 cycles on up → no vote change.
5. `PADDLE_ACCEL_EN`, down held 7 windows, then released 1 window, then held again → +1,+1,+2,+2,+3,+3,+3, 0, +1.
6. `rst` pulsed at counter 8 with up held → no strobe during reset; next strobe 16 cycles after release with −1; with `PADDLE_ACCEL_EN`, speed restarts at 1.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared types and width helpers for the paddle_array input controller.
// PADDLE_ACCEL_EN (optional) enables the hold-to-accelerate speed ramp.
package paddle_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } paddle_dir_t;

   function automatic int speed_width(input int max_speed);
      return $clog2(max_speed + 1) + 1;
   endfunction

   function automatic int acc_width(input int window_clocks);
      return $clog2(window_clocks + 1) + 1;
   endfunction

   // Screen-Y convention: moving up the screen is a negative step.
   function automatic logic signed [15:0] dir_to_step(input paddle_dir_t dir,
                                                      input logic [15:0] speed);
      logic signed [15:0] step;
      case (dir)
         UP:      step = -$signed(speed);
         DOWN:    step = $signed(speed);
         default: step = '0;
      endcase
      return step;
   endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: synchronise + debounce both buttons, accumulate up-down over the
// window, vote at close and (with PADDLE_ACCEL_EN) ramp the step magnitude.
module paddle_channel
   import paddle_pkg::*;
#(
   parameter int WINDOW_CLOCKS            = 250000,
   parameter int DEBOUNCE_WIDTH_IN_CLOCKS = 50000,
   parameter int VOTE_THRESHOLD           = WINDOW_CLOCKS,
   parameter int MAX_SPEED                = 4,
   parameter int ACCEL_WINDOWS            = 8,
   localparam int SPEED_W                 = speed_width(MAX_SPEED)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               button_up_i,
   input  logic               button_down_i,
   input  logic               close_i,
   output logic [SPEED_W-1:0] step_o
);

   localparam int AW  = acc_width(WINDOW_CLOCKS);
   localparam int DBW = $clog2(DEBOUNCE_WIDTH_IN_CLOCKS + 1);
   localparam logic [DBW-1:0]       DB_LAST = DBW'(DEBOUNCE_WIDTH_IN_CLOCKS - 1);
   localparam logic signed [AW-1:0] THR_P   = AW'(VOTE_THRESHOLD);
   localparam logic signed [AW-1:0] THR_N   = -THR_P;

   if (MAX_SPEED < 1) begin : g_chk_speed
      $error("paddle_channel: MAX_SPEED must be >= 1");
   end
   if (ACCEL_WINDOWS < 1) begin : g_chk_accel
      $error("paddle_channel: ACCEL_WINDOWS must be >= 1");
   end
   if (DEBOUNCE_WIDTH_IN_CLOCKS < 1) begin : g_chk_db
      $error("paddle_channel: DEBOUNCE_WIDTH_IN_CLOCKS must be >= 1");
   end

   // bit 0 = up, bit 1 = down
   logic [1:0]          raw;
   logic [1:0]          meta_q, sync_q, db_q;
   logic [1:0][DBW-1:0] dcnt_q;

   assign raw = {button_down_i, button_up_i};

   // Synchroniser flops are deliberately not reset: a button held through
   // reset is already visible to the debouncer on the first free cycle.
   always_ff @(posedge clk) begin
      meta_q <= raw;
      sync_q <= meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         db_q   <= '0;
         dcnt_q <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (sync_q[b] == db_q[b]) begin
               dcnt_q[b] <= '0;
            end else if (dcnt_q[b] == DB_LAST) begin
               db_q[b]   <= sync_q[b];
               dcnt_q[b] <= '0;
            end else begin
               dcnt_q[b] <= dcnt_q[b] + 1'b1;
            end
         end
      end
   end

   logic signed [AW-1:0] acc_q, delta, sum;
   paddle_dir_t          dir;

   always_comb begin
      case (db_q)
         2'b01:   delta = AW'(1);
         2'b10:   delta = {AW{1'b1}};
         default: delta = '0;
      endcase
      sum = acc_q + delta;
      if (sum >= THR_P)      dir = UP;
      else if (sum <= THR_N) dir = DOWN;
      else                   dir = NONE;
   end

   always_ff @(posedge clk) begin
      if (rst)          acc_q <= '0;
      else if (close_i) acc_q <= '0;
      else              acc_q <= sum;
   end

   logic [SPEED_W-1:0] speed_d;

`ifdef PADDLE_ACCEL_EN
   localparam int RW = $clog2(ACCEL_WINDOWS + 1);
   logic [SPEED_W-1:0] speed_q;
   logic [RW-1:0]      run_q, run_d;
   paddle_dir_t        prev_q;

   always_comb begin
      speed_d = speed_q;
      run_d   = run_q;
      if (dir == NONE || dir != prev_q) begin
         speed_d = SPEED_W'(1);
         run_d   = '0;
      end else if (run_q == RW'(ACCEL_WINDOWS - 1)) begin
         run_d = '0;
         if (speed_q != SPEED_W'(MAX_SPEED)) speed_d = speed_q + 1'b1;
      end else begin
         run_d = run_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         speed_q <= SPEED_W'(1);
         run_q   <= '0;
         prev_q  <= NONE;
      end else if (close_i) begin
         speed_q <= speed_d;
         run_q   <= run_d;
         prev_q  <= dir;
      end
   end
`else
   assign speed_d = SPEED_W'(1);
`endif

   assign step_o = SPEED_W'(dir_to_step(dir, 16'(speed_d)));

endmodule

// File: rtl/paddle_array.sv
// NUM_PADDLES-channel paddle controller: shared window counter, per-channel
// vote, registered outputs. PADDLE_ACCEL_EN enables the speed ramp.
module paddle_array
   import paddle_pkg::*;
#(
   parameter int NUM_PADDLES              = 2,
   parameter int WINDOW_CLOCKS            = 250000,
   parameter int DEBOUNCE_WIDTH_IN_CLOCKS = 50000,
   parameter int VOTE_THRESHOLD           = WINDOW_CLOCKS,
   parameter int MAX_SPEED                = 4,
   parameter int ACCEL_WINDOWS            = 8,
   localparam int SPEED_W                 = speed_width(MAX_SPEED)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PADDLES-1:0]         button_up,
   input  logic [NUM_PADDLES-1:0]         button_down,
   output logic [NUM_PADDLES*SPEED_W-1:0] position_change,
   output logic                           change_valid
);

   localparam int CW = $clog2(WINDOW_CLOCKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW_CLOCKS - 1);

   if (WINDOW_CLOCKS < 2) begin : g_chk_window
      $error("paddle_array: WINDOW_CLOCKS must be >= 2");
   end
   if (!(WINDOW_CLOCKS / 2 < VOTE_THRESHOLD && VOTE_THRESHOLD <= WINDOW_CLOCKS)) begin : g_chk_vote
      $error("paddle_array: need WINDOW_CLOCKS/2 < VOTE_THRESHOLD <= WINDOW_CLOCKS");
   end

   logic [CW-1:0]                  cnt_q, cnt_d;
   logic                           close;
   logic [NUM_PADDLES*SPEED_W-1:0] step_all, pc_q;
   logic                           cv_q;

   assign close = (cnt_q == CNT_LAST);
   assign cnt_d = close ? '0 : cnt_q + 1'b1;

   for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_ch
      paddle_channel #(
         .WINDOW_CLOCKS           (WINDOW_CLOCKS),
         .DEBOUNCE_WIDTH_IN_CLOCKS(DEBOUNCE_WIDTH_IN_CLOCKS),
         .VOTE_THRESHOLD          (VOTE_THRESHOLD),
         .MAX_SPEED               (MAX_SPEED),
         .ACCEL_WINDOWS           (ACCEL_WINDOWS)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .button_up_i  (button_up[g]),
         .button_down_i(button_down[g]),
         .close_i      (close),
         .step_o       (step_all[g*SPEED_W +: SPEED_W])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         pc_q  <= '0;
         cv_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         cv_q  <= close;
         if (close) pc_q <= step_all;
      end
   end

   assign position_change = pc_q;
   assign change_valid    = cv_q;

endmodule

// File: tb/tb_paddle_array.sv
// Self-checking bench for paddle_array: directed scenarios plus random button
// activity, compared every cycle against a behavioural window-vote model.
module tb_paddle_array;

   localparam int NP  = 2;
   localparam int W   = 16;
   localparam int DB  = 4;
   localparam int THR = 12;
   localparam int MS  = 3;
   localparam int ACW = 2;
   localparam int SW  = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NP-1:0]    bu  = '0;
   logic [NP-1:0]    bd  = '0;
   logic [NP*SW-1:0] pc;
   logic             cv;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   paddle_array #(
      .NUM_PADDLES             (NP),
      .WINDOW_CLOCKS           (W),
      .DEBOUNCE_WIDTH_IN_CLOCKS(DB),
      .VOTE_THRESHOLD          (THR),
      .MAX_SPEED               (MS),
      .ACCEL_WINDOWS           (ACW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .button_up      (bu),
      .button_down    (bd),
      .position_change(pc),
      .change_valid   (cv)
   );

   // Reference model state (index b: 0 = up button, 1 = down button)
   int wcnt;
   int acc    [NP];
   int dbv    [NP][2];
   int lastv  [NP][2];
   int runlen [NP][2];
   bit hist   [NP*2][$];
   int spd    [NP];
   int runc   [NP];
   int prevd  [NP];
   int exp_pc [NP];
   int exp_cv;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the specified behaviour; dir 0=none 1=up 2=down.
   task automatic model_edge();
      bit close;
      int delta, sum, dir, sp, seen;
      bit rawv;
      // the two-flop synchroniser is a pure 2-cycle delay line, never reset
      for (int p = 0; p < NP; p++)
         for (int b = 0; b < 2; b++) begin
            rawv = (b == 0) ? bu[p] : bd[p];
            hist[p*2+b].push_front(rawv);
            if (hist[p*2+b].size() > 3) void'(hist[p*2+b].pop_back());
         end
      if (rst) begin
         wcnt   = 0;
         exp_cv = 0;
         for (int p = 0; p < NP; p++) begin
            acc[p] = 0; exp_pc[p] = 0; spd[p] = 1; runc[p] = 0; prevd[p] = 0;
            for (int b = 0; b < 2; b++) begin
               dbv[p][b] = 0; lastv[p][b] = 0; runlen[p][b] = 0;
            end
         end
      end else begin
         close = (wcnt == W - 1);
         for (int p = 0; p < NP; p++) begin
            delta = dbv[p][0] - dbv[p][1];
            sum   = acc[p] + delta;
            if (close) begin
               dir = (sum >= THR) ? 1 : (sum <= -THR) ? 2 : 0;
`ifdef PADDLE_ACCEL_EN
               if (dir == 0 || dir != prevd[p]) begin
                  spd[p] = 1; runc[p] = 0;
               end else begin
                  runc[p]++;
                  if (runc[p] == ACW) begin
                     runc[p] = 0;
                     if (spd[p] < MS) spd[p]++;
                  end
               end
               prevd[p] = dir;
               sp = spd[p];
`else
               sp = 1;
`endif
               exp_pc[p] = (dir == 1) ? -sp : (dir == 2) ? sp : 0;
               acc[p] = 0;
            end else begin
               acc[p] = sum;
            end
            // debouncer: adopt a level once it has been seen for DB edges in a row
            for (int b = 0; b < 2; b++) begin
               seen = (hist[p*2+b].size() >= 3) ? int'(hist[p*2+b][2]) : 0;
               if (seen == lastv[p][b]) runlen[p][b]++;
               else runlen[p][b] = 1;
               lastv[p][b] = seen;
               if (runlen[p][b] >= DB && seen != dbv[p][b]) dbv[p][b] = seen;
            end
         end
         exp_cv = close ? 1 : 0;
         wcnt   = close ? 0 : wcnt + 1;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      for (int p = 0; p < NP; p++)
         chk($sformatf("pos_change[%0d]", p), int'($signed(pc[p*SW +: SW])), exp_pc[p]);
      chk("change_valid", int'(cv), exp_cv);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_wc(input int t);
      for (int i = 0; i < W + 1 && wcnt != t; i++) cycle();
   endtask

   initial begin
      // reset, idle windows
      rst = 1'b1;
      run(3);
      rst = 1'b0;
      run(40);

      // single-paddle holds
      bu[0] = 1'b1; run(40); bu = '0;
      bd[1] = 1'b1; run(40); bd = '0;
      run(20);

      // threshold boundary: debounced high lands on window cycles 0..L-1
      for (int k = 0; k < 4; k++) begin
         wait_wc(10);
         bu[0] = 1'b1;
         run((k % 2 == 0) ? 11 : 12);
         bu[0] = 1'b0;
         run(30);
      end

      // both buttons, then short bounces that never pass the debouncer
      bu[0] = 1'b1; bd[0] = 1'b1; run(40);
      bu = '0; bd = '0;
      for (int i = 0; i < 12; i++) begin
         bu[0] = 1'b1; run($urandom_range(1, 3));
         bu[0] = 1'b0; run($urandom_range(1, 3));
      end
      run(20);

      // long hold / release / hold (speed ramp when enabled)
      bd[0] = 1'b1; run(7 * W);
      bd[0] = 1'b0; run(W);
      bd[0] = 1'b1; run(2 * W);
      bd[0] = 1'b0; run(20);

      // reset pulsed mid-window with up held
      bu[0] = 1'b1; run(3 * W);
      wait_wc(8);
      rst = 1'b1; run(2);
      rst = 1'b0; run(3 * W);
      bu = '0;
      run(20);

      // random segments
      for (int s = 0; s < 60; s++) begin
         case ($urandom_range(0, 5))
            0: begin bu = '0; bd = '0; end
            1: begin bu = 2'b01; bd = '0; end
            2: begin bu = '0; bd = 2'b10; end
            3: begin bu = 2'b01; bd = 2'b01; end
            4: begin bu = 2'($urandom_range(0, 3)); bd = 2'($urandom_range(0, 3)); end
            default: begin
               for (int i = 0; i < 8; i++) begin
                  bu = 2'($urandom_range(0, 3));
                  bd = 2'($urandom_range(0, 3));
                  run($urandom_range(1, 3));
               end
            end
         endcase
         run($urandom_range(5, 60));
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1; run($urandom_range(1, 3)); rst = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
